// File: rtl/logic16_arbiter_pkg.sv
// Shared definitions for the logic16 arbiter: opcodes, FSM states and the
// 16-bit bitwise function evaluated on the latched operands.
package logic16_arbiter_pkg;

   localparam logic [1:0] OP_AND  = 2'b00;
   localparam logic [1:0] OP_OR   = 2'b01;
   localparam logic [1:0] OP_NOT  = 2'b10;
   localparam logic [1:0] OP_PASS = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   function automatic logic [15:0] logic16_eval(input logic [1:0]  op_v,
                                                input logic [15:0] a_v,
                                                input logic [15:0] b_v);
      logic [15:0] res_v;
      case (op_v)
         OP_AND:  res_v = a_v & b_v;
         OP_OR:   res_v = a_v | b_v;
         OP_NOT:  res_v = ~a_v;
         OP_PASS: res_v = a_v;
         default: res_v = 16'h0000;
      endcase
      return res_v;
   endfunction

endpackage

// File: rtl/logic16_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit at or above ptr,
// wrapping modulo N. Reusable by any arbiter that keeps its own pointer.
module rr_pick #(
   parameter int N   = 4,
   parameter int IDW = 2
) (
   input  logic [N-1:0]   req,
   input  logic [IDW-1:0] ptr,
   output logic [N-1:0]   onehot,
   output logic [IDW-1:0] index,
   output logic           found
);

   function automatic int wrap_idx(input int base, input int step);
      return (base + step) % N;
   endfunction

   logic [IDW-1:0] cand_s;

   // Scan candidates in priority order starting from ptr; first hit wins.
   always_comb begin
      onehot = {N{1'b0}};
      index  = {IDW{1'b0}};
      found  = 1'b0;
      cand_s = {IDW{1'b0}};
      for (int k = 0; k < N; k++) begin
         cand_s = IDW'(wrap_idx(int'(ptr), k));
         if (!found && req[cand_s]) begin
            found          = 1'b1;
            index          = cand_s;
            onehot[cand_s] = 1'b1;
         end else begin
            found = found;
         end
      end
   end

endmodule

// File: rtl/logic16_arbiter.sv
// Round-robin arbiter sharing one 16-bit bitwise logic unit among N clients;
// operands are latched on grant and the result returned via valid/ready.
module logic16_arbiter
   import logic16_arbiter_pkg::*;
#(
   parameter int N   = 4,
   parameter int IDW = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N-1:0]    req,
   input  logic [2*N-1:0]  op,
   input  logic [16*N-1:0] a,
   input  logic [16*N-1:0] b,
   output logic [N-1:0]    grant,
   output logic [15:0]     out,
   output logic            out_valid,
   output logic [IDW-1:0]  out_id,
   input  logic            out_ready,
   output logic            busy
);

   state_t         state_r;
   logic [IDW-1:0] ptr_r;
   logic [1:0]     op_l_r;
   logic [15:0]    a_l_r;
   logic [15:0]    b_l_r;

   logic [N-1:0]   pick_onehot_s;
   logic [IDW-1:0] pick_index_s;
   logic           pick_found_s;
   logic [1:0]     op_sel_s;
   logic [15:0]    a_sel_s;
   logic [15:0]    b_sel_s;

   rr_pick #(.N(N), .IDW(IDW)) u_rr_pick (
      .req    (req),
      .ptr    (ptr_r),
      .onehot (pick_onehot_s),
      .index  (pick_index_s),
      .found  (pick_found_s)
   );

   // Route the winner's operand lanes to the capture registers.
   always_comb begin
      op_sel_s = 2'b00;
      a_sel_s  = 16'h0000;
      b_sel_s  = 16'h0000;
      for (int i = 0; i < N; i++) begin
         if (pick_onehot_s[i]) begin
            op_sel_s = op[2*i +: 2];
            a_sel_s  = a[16*i +: 16];
            b_sel_s  = b[16*i +: 16];
         end else begin
            op_sel_s = op_sel_s;
         end
      end
   end

   // Arbitration FSM with registered grant/result/handshake outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= IDLE;
         ptr_r     <= {IDW{1'b0}};
         op_l_r    <= 2'b00;
         a_l_r     <= 16'h0000;
         b_l_r     <= 16'h0000;
         grant     <= {N{1'b0}};
         out       <= 16'h0000;
         out_valid <= 1'b0;
         out_id    <= {IDW{1'b0}};
         busy      <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (pick_found_s) begin
                  op_l_r  <= op_sel_s;
                  a_l_r   <= a_sel_s;
                  b_l_r   <= b_sel_s;
                  out_id  <= pick_index_s;
                  grant   <= pick_onehot_s;
                  busy    <= 1'b1;
                  state_r <= EXEC;
               end else begin
                  grant   <= {N{1'b0}};
               end
            end
            EXEC: begin
               grant     <= {N{1'b0}};
               out       <= logic16_eval(op_l_r, a_l_r, b_l_r);
               out_valid <= 1'b1;
               state_r   <= RESP;
            end
            RESP: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  state_r   <= IDLE;
                  // Just-served requester drops to lowest priority.
                  if (out_id == IDW'(N - 1)) begin
                     ptr_r <= {IDW{1'b0}};
                  end else begin
                     ptr_r <= out_id + {{(IDW-1){1'b0}}, 1'b1};
                  end
               end else begin
                  out_valid <= 1'b1;
               end
            end
            default: begin
               grant     <= {N{1'b0}};
               out_valid <= 1'b0;
               busy      <= 1'b0;
               state_r   <= IDLE;
            end
         endcase
      end
   end

endmodule
